// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline controller.
//   pc_src_e      : PC source select driven to the fetch stage
//   fwd_sel_e     : ID-stage operand forwarding select
//   run_state_e   : debug run-control states
//   stage_ctrl_t  : one bit per pipeline stage (IF..WB), used for rst/en vectors
package pipeline_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned PC_W       = 32;
  localparam int unsigned SEL_W      = 2;

  typedef enum logic [SEL_W-1:0] {
    PC_NEXT   = 2'd0,
    PC_JUMP   = 2'd1,
    PC_BRANCH = 2'd2,
    PC_JR     = 2'd3
  } pc_src_e;

  typedef enum logic [SEL_W-1:0] {
    FWD_RF       = 2'd0,
    FWD_EXE      = 2'd1,
    FWD_MEM_ALU  = 2'd2,
    FWD_MEM_LOAD = 2'd3
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } run_state_e;

  typedef struct packed {
    logic if_s;
    logic id_s;
    logic exe_s;
    logic mem_s;
    logic wb_s;
  } stage_ctrl_t;

  // Forwarding source for one ID operand; EXE wins over MEM, $0 never forwards,
  // and a load still in EXE has no data yet so it cannot be an EXE source.
  function automatic fwd_sel_e fwd_select(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  wen_exe,
    input logic [REG_ADDR_W-1:0] dst_exe,
    input logic                  load_exe,
    input logic                  wen_mem,
    input logic [REG_ADDR_W-1:0] dst_mem,
    input logic                  load_mem
  );
    fwd_sel_e sel;
    sel = FWD_RF;
    if (src != '0) begin
      if (wen_exe && (dst_exe == src) && !load_exe) begin
        sel = FWD_EXE;
      end else if (wen_mem && (dst_mem == src)) begin
        sel = load_mem ? FWD_MEM_LOAD : FWD_MEM_ALU;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// Combinational forwarding selects and load-use hazard detection.
// Inputs : ID source registers and usage flags, destination register / write
//          enable / load flags of EXE, MEM and WB, MEM store rt.
// Outputs: fwd_a_c / fwd_b_c (ID operand selects), fwd_mem_c (store data from
//          WB), load_use_c (ID must wait one cycle for a load in EXE).
module pipeline_ctrl_fwd_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] addr_rs,
  input  logic [REG_ADDR_W-1:0] addr_rt,
  input  logic                  rs_used,
  input  logic                  rt_used,
  input  logic                  is_store,
  input  logic [REG_ADDR_W-1:0] regw_addr_exe,
  input  logic [REG_ADDR_W-1:0] regw_addr_mem,
  input  logic [REG_ADDR_W-1:0] regw_addr_wb,
  input  logic                  wb_wen_exe,
  input  logic                  wb_wen_mem,
  input  logic                  wb_wen_wb,
  input  logic                  is_load_exe,
  input  logic                  is_load_mem,
  input  logic                  is_store_mem,
  input  logic [REG_ADDR_W-1:0] rt_addr_mem,
  output fwd_sel_e              fwd_a_c,
  output fwd_sel_e              fwd_b_c,
  output logic                  fwd_mem_c,
  output logic                  load_use_c
);

  logic load_in_exe;
  logic rs_hit;
  logic rt_hit;

  // Operand forwarding selects.
  always_comb begin
    fwd_a_c = fwd_select(addr_rs, wb_wen_exe, regw_addr_exe, is_load_exe,
                         wb_wen_mem, regw_addr_mem, is_load_mem);
    fwd_b_c = fwd_select(addr_rt, wb_wen_exe, regw_addr_exe, is_load_exe,
                         wb_wen_mem, regw_addr_mem, is_load_mem);
  end

  // Store data in MEM replaced by the value being written back this cycle.
  always_comb begin
    fwd_mem_c = is_store_mem && wb_wen_wb && (regw_addr_wb == rt_addr_mem) &&
                (rt_addr_mem != '0);
  end

  // A store whose only dependency is its data register (rt) need not stall:
  // that value is picked up later through fwd_mem.
  always_comb begin
    load_in_exe = is_load_exe && wb_wen_exe && (regw_addr_exe != '0);
    rs_hit      = rs_used && (addr_rs == regw_addr_exe);
    rt_hit      = rt_used && (addr_rt == regw_addr_exe) && !is_store;
    load_use_c  = load_in_exe && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard, forwarding and debug run-control sequencer for the 5-stage pipeline.
// Inputs : ID decode (sources, control transfer), per-stage destination info,
//          IF PC, debug pulses (halt/step/resume) and breakpoint setup.
// Outputs: per-stage rst/en, pc_src, fwd_a/fwd_b/fwd_mem (combinational from
//          this cycle's inputs), halted and cycle/stall/flush counters
//          (registered).
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter bit          START_HALTED = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] addr_rs,
  input  logic [REG_ADDR_W-1:0] addr_rt,
  input  logic                  rs_used,
  input  logic                  rt_used,
  input  logic                  is_store,
  input  logic                  is_jump,
  input  logic                  is_jr,
  input  logic                  is_beq,
  input  logic                  is_bne,
  input  logic                  rs_rt_equal,
  input  logic [REG_ADDR_W-1:0] regw_addr_exe,
  input  logic [REG_ADDR_W-1:0] regw_addr_mem,
  input  logic [REG_ADDR_W-1:0] regw_addr_wb,
  input  logic                  wb_wen_exe,
  input  logic                  wb_wen_mem,
  input  logic                  wb_wen_wb,
  input  logic                  is_load_exe,
  input  logic                  is_load_mem,
  input  logic                  is_store_mem,
  input  logic [REG_ADDR_W-1:0] rt_addr_mem,
  input  logic [PC_W-1:0]       inst_addr,
  input  logic                  dbg_halt_req,
  input  logic                  dbg_step,
  input  logic                  dbg_resume,
  input  logic                  bp_en,
  input  logic [PC_W-1:0]       bp_addr,
  output logic                  if_rst,
  output logic                  id_rst,
  output logic                  exe_rst,
  output logic                  mem_rst,
  output logic                  wb_rst,
  output logic                  if_en,
  output logic                  id_en,
  output logic                  exe_en,
  output logic                  mem_en,
  output logic                  wb_en,
  output logic [SEL_W-1:0]      pc_src,
  output logic [SEL_W-1:0]      fwd_a,
  output logic [SEL_W-1:0]      fwd_b,
  output logic                  fwd_mem,
  output logic                  halted,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam run_state_e RESET_STATE = START_HALTED ? ST_HALT : ST_RUN;

  run_state_e  state_q, state_d;
  logic        skip_bp_q, skip_bp_d;
  logic        halted_q, halted_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  fwd_sel_e    fwd_a_c, fwd_b_c;
  logic        fwd_mem_c, load_use_c;
  logic        bp_match_c, br_taken_c, advance_c;
  pc_src_e     xfer_sel_c, pc_sel_c;
  stage_ctrl_t stage_rst_c, stage_en_c;

  pipeline_ctrl_fwd_unit u_fwd (
    .addr_rs       (addr_rs),
    .addr_rt       (addr_rt),
    .rs_used       (rs_used),
    .rt_used       (rt_used),
    .is_store      (is_store),
    .regw_addr_exe (regw_addr_exe),
    .regw_addr_mem (regw_addr_mem),
    .regw_addr_wb  (regw_addr_wb),
    .wb_wen_exe    (wb_wen_exe),
    .wb_wen_mem    (wb_wen_mem),
    .wb_wen_wb     (wb_wen_wb),
    .is_load_exe   (is_load_exe),
    .is_load_mem   (is_load_mem),
    .is_store_mem  (is_store_mem),
    .rt_addr_mem   (rt_addr_mem),
    .fwd_a_c       (fwd_a_c),
    .fwd_b_c       (fwd_b_c),
    .fwd_mem_c     (fwd_mem_c),
    .load_use_c    (load_use_c)
  );

  // Breakpoint compare; suppressed on the first cycle after a resume so the
  // pipeline can move past the instruction it stopped on.
  always_comb begin
    bp_match_c = bp_en && (inst_addr == bp_addr) && !skip_bp_q;
  end

  // Control-transfer decode in ID.
  always_comb begin
    br_taken_c = (is_beq && rs_rt_equal) || (is_bne && !rs_rt_equal);
    xfer_sel_c = PC_NEXT;
    if (is_jump) begin
      xfer_sel_c = PC_JUMP;
    end else if (is_jr) begin
      xfer_sel_c = PC_JR;
    end else if (br_taken_c) begin
      xfer_sel_c = PC_BRANCH;
    end
  end

  // Run-control next state, stage controls and counter updates.
  always_comb begin
    state_d     = state_q;
    skip_bp_d   = 1'b0;
    advance_c   = 1'b0;
    stage_rst_c = '0;
    stage_en_c  = '0;
    pc_sel_c    = PC_NEXT;
    cycle_d     = cycle_q;
    stall_d     = stall_q;
    flush_d     = flush_q;

    case (state_q)
      ST_RUN: begin
        // The cycle that decides to halt is already frozen.
        if (dbg_halt_req || bp_match_c) begin
          state_d = ST_HALT;
        end else begin
          advance_c = 1'b1;
        end
      end
      ST_HALT: begin
        if (dbg_resume) begin
          state_d   = ST_RUN;
          skip_bp_d = 1'b1;
        end else if (dbg_step) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        advance_c = 1'b1;
        state_d   = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase

    if (advance_c) begin
      stage_en_c = '1;
      cycle_d    = cycle_q + CNT_W'(1);
      if (load_use_c) begin
        // Hold IF/ID and push a bubble into EXE; the transfer waits too.
        stage_en_c.if_s   = 1'b0;
        stage_en_c.id_s   = 1'b0;
        stage_rst_c.exe_s = 1'b1;
        stall_d           = stall_q + CNT_W'(1);
      end else if (xfer_sel_c != PC_NEXT) begin
        // No delay slot: squash the instruction fetched behind the transfer.
        pc_sel_c         = xfer_sel_c;
        stage_rst_c.id_s = 1'b1;
        flush_d          = flush_q + CNT_W'(1);
      end
    end

    halted_d = (state_d == ST_HALT);
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      skip_bp_q <= 1'b0;
      halted_q  <= START_HALTED;
      cycle_q   <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      skip_bp_q <= skip_bp_d;
      halted_q  <= halted_d;
      cycle_q   <= cycle_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  // Output drive; reset overrides every stage control and select.
  always_comb begin
    if (rst) begin
      {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = '1;
      {if_en, id_en, exe_en, mem_en, wb_en}      = '0;
      pc_src  = PC_NEXT;
      fwd_a   = FWD_RF;
      fwd_b   = FWD_RF;
      fwd_mem = 1'b0;
    end else begin
      {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = stage_rst_c;
      {if_en, id_en, exe_en, mem_en, wb_en}      = stage_en_c;
      pc_src  = pc_sel_c;
      fwd_a   = fwd_a_c;
      fwd_b   = fwd_b_c;
      fwd_mem = fwd_mem_c;
    end
  end

  assign halted    = halted_q;
  assign cycle_cnt = cycle_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: table of single-cycle vectors followed by
// hand-written multi-cycle debug and reset sequences.
module tb_pipeline_ctrl;

  localparam int unsigned CNT_W = 32;

  typedef struct packed {
    logic        rst;
    logic [4:0]  addr_rs;
    logic [4:0]  addr_rt;
    logic        rs_used;
    logic        rt_used;
    logic        is_store;
    logic        is_jump;
    logic        is_jr;
    logic        is_beq;
    logic        is_bne;
    logic        rs_rt_equal;
    logic [4:0]  regw_addr_exe;
    logic [4:0]  regw_addr_mem;
    logic [4:0]  regw_addr_wb;
    logic        wb_wen_exe;
    logic        wb_wen_mem;
    logic        wb_wen_wb;
    logic        is_load_exe;
    logic        is_load_mem;
    logic        is_store_mem;
    logic [4:0]  rt_addr_mem;
    logic [31:0] inst_addr;
    logic        dbg_halt_req;
    logic        dbg_step;
    logic        dbg_resume;
    logic        bp_en;
    logic [31:0] bp_addr;
  } in_t;

  // rsts/ens ordered {if, id, exe, mem, wb}
  typedef struct packed {
    logic [4:0]  rsts;
    logic [4:0]  ens;
    logic [1:0]  pc;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        fm;
    logic        halted;
    logic [31:0] cyc;
    logic [31:0] stl;
    logic [31:0] fls;
  } exp_t;

  typedef struct {
    string name;
    in_t   in;
    exp_t  exp;
  } vec_t;

  localparam logic [4:0] R_NONE   = 5'b00000;
  localparam logic [4:0] R_ALL    = 5'b11111;
  localparam logic [4:0] R_ID     = 5'b01000;
  localparam logic [4:0] R_EXE    = 5'b00100;
  localparam logic [4:0] EN_NONE  = 5'b00000;
  localparam logic [4:0] EN_ALL   = 5'b11111;
  localparam logic [4:0] EN_STALL = 5'b00111;

  logic clk;
  logic rst;
  logic [4:0]  addr_rs, addr_rt;
  logic        rs_used, rt_used, is_store;
  logic        is_jump, is_jr, is_beq, is_bne, rs_rt_equal;
  logic [4:0]  regw_addr_exe, regw_addr_mem, regw_addr_wb;
  logic        wb_wen_exe, wb_wen_mem, wb_wen_wb;
  logic        is_load_exe, is_load_mem, is_store_mem;
  logic [4:0]  rt_addr_mem;
  logic [31:0] inst_addr;
  logic        dbg_halt_req, dbg_step, dbg_resume, bp_en;
  logic [31:0] bp_addr;
  logic        if_rst, id_rst, exe_rst, mem_rst, wb_rst;
  logic        if_en, id_en, exe_en, mem_en, wb_en;
  logic [1:0]  pc_src, fwd_a, fwd_b;
  logic        fwd_mem, halted;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;

  int checks;
  int errors;
  vec_t vecs[$];

  pipeline_ctrl #(.CNT_W(CNT_W), .START_HALTED(1'b0)) dut (
    .clk           (clk),
    .rst           (rst),
    .addr_rs       (addr_rs),
    .addr_rt       (addr_rt),
    .rs_used       (rs_used),
    .rt_used       (rt_used),
    .is_store      (is_store),
    .is_jump       (is_jump),
    .is_jr         (is_jr),
    .is_beq        (is_beq),
    .is_bne        (is_bne),
    .rs_rt_equal   (rs_rt_equal),
    .regw_addr_exe (regw_addr_exe),
    .regw_addr_mem (regw_addr_mem),
    .regw_addr_wb  (regw_addr_wb),
    .wb_wen_exe    (wb_wen_exe),
    .wb_wen_mem    (wb_wen_mem),
    .wb_wen_wb     (wb_wen_wb),
    .is_load_exe   (is_load_exe),
    .is_load_mem   (is_load_mem),
    .is_store_mem  (is_store_mem),
    .rt_addr_mem   (rt_addr_mem),
    .inst_addr     (inst_addr),
    .dbg_halt_req  (dbg_halt_req),
    .dbg_step      (dbg_step),
    .dbg_resume    (dbg_resume),
    .bp_en         (bp_en),
    .bp_addr       (bp_addr),
    .if_rst        (if_rst),
    .id_rst        (id_rst),
    .exe_rst       (exe_rst),
    .mem_rst       (mem_rst),
    .wb_rst        (wb_rst),
    .if_en         (if_en),
    .id_en         (id_en),
    .exe_en        (exe_en),
    .mem_en        (mem_en),
    .wb_en         (wb_en),
    .pc_src        (pc_src),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .fwd_mem       (fwd_mem),
    .halted        (halted),
    .cycle_cnt     (cycle_cnt),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic in_t idle();
    in_t r;
    r = '0;
    return r;
  endfunction

  function automatic exp_t mk(input logic [4:0] rsts, input logic [4:0] ens,
                              input logic [1:0] pc, input logic [1:0] fa,
                              input logic [1:0] fb, input logic fm,
                              input logic hlt, input logic [31:0] cyc,
                              input logic [31:0] stl, input logic [31:0] fls);
    exp_t e;
    e.rsts = rsts; e.ens = ens; e.pc = pc; e.fa = fa; e.fb = fb;
    e.fm = fm; e.halted = hlt; e.cyc = cyc; e.stl = stl; e.fls = fls;
    return e;
  endfunction

  task automatic drive(input in_t i);
    rst = i.rst;
    addr_rs = i.addr_rs; addr_rt = i.addr_rt;
    rs_used = i.rs_used; rt_used = i.rt_used; is_store = i.is_store;
    is_jump = i.is_jump; is_jr = i.is_jr; is_beq = i.is_beq; is_bne = i.is_bne;
    rs_rt_equal = i.rs_rt_equal;
    regw_addr_exe = i.regw_addr_exe; regw_addr_mem = i.regw_addr_mem;
    regw_addr_wb = i.regw_addr_wb;
    wb_wen_exe = i.wb_wen_exe; wb_wen_mem = i.wb_wen_mem; wb_wen_wb = i.wb_wen_wb;
    is_load_exe = i.is_load_exe; is_load_mem = i.is_load_mem;
    is_store_mem = i.is_store_mem; rt_addr_mem = i.rt_addr_mem;
    inst_addr = i.inst_addr;
    dbg_halt_req = i.dbg_halt_req; dbg_step = i.dbg_step; dbg_resume = i.dbg_resume;
    bp_en = i.bp_en; bp_addr = i.bp_addr;
  endtask

  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h, expected %0h", name, field, act, exp);
    end
  endtask

  task automatic check_all(input string name, input exp_t e);
    cmp(name, "rsts",   32'({if_rst, id_rst, exe_rst, mem_rst, wb_rst}), 32'(e.rsts));
    cmp(name, "ens",    32'({if_en, id_en, exe_en, mem_en, wb_en}), 32'(e.ens));
    cmp(name, "pc_src", 32'(pc_src), 32'(e.pc));
    cmp(name, "fwd_a",  32'(fwd_a), 32'(e.fa));
    cmp(name, "fwd_b",  32'(fwd_b), 32'(e.fb));
    cmp(name, "fwd_mem", 32'(fwd_mem), 32'(e.fm));
    cmp(name, "halted", 32'(halted), 32'(e.halted));
    cmp(name, "cycle_cnt", 32'(cycle_cnt), e.cyc);
    cmp(name, "stall_cnt", 32'(stall_cnt), e.stl);
    cmp(name, "flush_cnt", 32'(flush_cnt), e.fls);
  endtask

  // Drive after one edge, sample combinational and registered outputs on the
  // falling edge before the next rising edge.
  task automatic apply(input string name, input in_t i, input exp_t e);
    @(posedge clk);
    #1 drive(i);
    @(negedge clk);
    check_all(name, e);
  endtask

  task automatic add(input string n, input in_t i, input exp_t e);
    vec_t v;
    v.name = n; v.in = i; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    in_t i;
    in_t bp;
    checks = 0;
    errors = 0;

    // Reset state, with an EXE match present that reset must mask.
    i = idle(); i.rst = 1; i.addr_rs = 3; i.wb_wen_exe = 1; i.regw_addr_exe = 3;
    add("reset", i, mk(R_ALL, EN_NONE, 0, 0, 0, 0, 0, 0, 0, 0));
    // add $3 in EXE, sub $4,$3,$5 in ID
    i = idle(); i.addr_rs = 3; i.addr_rt = 5; i.rs_used = 1; i.rt_used = 1;
    i.regw_addr_exe = 3; i.wb_wen_exe = 1; i.inst_addr = 32'h4;
    add("exe_fwd_rs", i, mk(R_NONE, EN_ALL, 0, 1, 0, 0, 0, 0, 0, 0));
    // lw $3 in EXE, add $4,$3,$3 in ID
    i = idle(); i.addr_rs = 3; i.addr_rt = 3; i.rs_used = 1; i.rt_used = 1;
    i.regw_addr_exe = 3; i.wb_wen_exe = 1; i.is_load_exe = 1;
    add("load_use_stall", i, mk(R_EXE, EN_STALL, 0, 0, 0, 0, 0, 1, 0, 0));
    // bubble in EXE, lw in MEM
    i = idle(); i.addr_rs = 3; i.addr_rt = 3; i.rs_used = 1; i.rt_used = 1;
    i.regw_addr_mem = 3; i.wb_wen_mem = 1; i.is_load_mem = 1;
    add("after_stall_load_fwd", i, mk(R_NONE, EN_ALL, 0, 3, 3, 0, 0, 2, 1, 0));
    // lw $3 in EXE, sw $3,4($0) in ID: rt-only store match, no stall
    i = idle(); i.addr_rs = 0; i.addr_rt = 3; i.rs_used = 1; i.rt_used = 1; i.is_store = 1;
    i.regw_addr_exe = 3; i.wb_wen_exe = 1; i.is_load_exe = 1;
    add("store_rt_no_stall", i, mk(R_NONE, EN_ALL, 0, 0, 0, 0, 0, 3, 1, 0));
    // sw $3 in MEM, lw $3 in WB
    i = idle(); i.is_store_mem = 1; i.rt_addr_mem = 3; i.regw_addr_wb = 3; i.wb_wen_wb = 1;
    add("fwd_mem_store", i, mk(R_NONE, EN_ALL, 0, 0, 0, 1, 0, 4, 1, 0));
    // beq $1,$1 taken
    i = idle(); i.addr_rs = 1; i.addr_rt = 1; i.rs_used = 1; i.rt_used = 1;
    i.is_beq = 1; i.rs_rt_equal = 1;
    add("beq_taken", i, mk(R_ID, EN_ALL, 2, 0, 0, 0, 0, 5, 1, 0));
    // bne with equal operands: not taken
    i = idle(); i.addr_rs = 1; i.addr_rt = 1; i.rs_used = 1; i.rt_used = 1;
    i.is_bne = 1; i.rs_rt_equal = 1;
    add("bne_not_taken", i, mk(R_NONE, EN_ALL, 0, 0, 0, 0, 0, 6, 1, 1));
    i = idle(); i.is_jump = 1;
    add("jump", i, mk(R_ID, EN_ALL, 1, 0, 0, 0, 0, 7, 1, 1));
    i = idle(); i.is_jr = 1; i.addr_rs = 31; i.rs_used = 1;
    add("jr", i, mk(R_ID, EN_ALL, 3, 0, 0, 0, 0, 8, 1, 2));
    // Writes to $0 in EXE (a load) and MEM, ID reads $0
    i = idle(); i.addr_rs = 0; i.addr_rt = 0; i.rs_used = 1; i.rt_used = 1;
    i.regw_addr_exe = 0; i.wb_wen_exe = 1; i.is_load_exe = 1;
    i.regw_addr_mem = 0; i.wb_wen_mem = 1;
    add("reg0_never", i, mk(R_NONE, EN_ALL, 0, 0, 0, 0, 0, 9, 1, 3));
    // Load-use stall beats a taken branch
    i = idle(); i.addr_rs = 2; i.addr_rt = 6; i.rs_used = 1; i.rt_used = 1;
    i.regw_addr_exe = 2; i.wb_wen_exe = 1; i.is_load_exe = 1;
    i.is_beq = 1; i.rs_rt_equal = 1;
    add("stall_over_branch", i, mk(R_EXE, EN_STALL, 0, 0, 0, 0, 0, 10, 1, 3));
    // EXE and MEM both match rs: EXE wins
    i = idle(); i.addr_rs = 7; i.addr_rt = 8; i.rs_used = 1; i.rt_used = 1;
    i.regw_addr_exe = 7; i.wb_wen_exe = 1; i.regw_addr_mem = 7; i.wb_wen_mem = 1;
    i.is_load_mem = 1;
    add("exe_over_mem", i, mk(R_NONE, EN_ALL, 0, 1, 0, 0, 0, 11, 2, 3));
    // rs matches a load but is unused; rt from MEM ALU result
    i = idle(); i.addr_rs = 7; i.addr_rt = 9; i.rs_used = 0; i.rt_used = 1;
    i.regw_addr_exe = 7; i.wb_wen_exe = 1; i.is_load_exe = 1;
    i.regw_addr_mem = 9; i.wb_wen_mem = 1;
    add("mem_alu_rt", i, mk(R_NONE, EN_ALL, 0, 0, 2, 0, 0, 12, 2, 3));
    // Store whose base (rs) depends on the load still stalls; fwd_mem off for $0
    i = idle(); i.addr_rs = 4; i.addr_rt = 4; i.rs_used = 1; i.rt_used = 1; i.is_store = 1;
    i.regw_addr_exe = 4; i.wb_wen_exe = 1; i.is_load_exe = 1;
    i.is_store_mem = 1; i.rt_addr_mem = 0; i.regw_addr_wb = 0; i.wb_wen_wb = 1;
    add("store_rs_stall", i, mk(R_EXE, EN_STALL, 0, 0, 0, 0, 0, 13, 2, 3));
    // rt-only load-use for a non-store
    i = idle(); i.addr_rs = 1; i.addr_rt = 5; i.rs_used = 1; i.rt_used = 1;
    i.regw_addr_exe = 5; i.wb_wen_exe = 1; i.is_load_exe = 1;
    add("rt_load_use", i, mk(R_EXE, EN_STALL, 0, 0, 0, 0, 0, 14, 3, 3));

    // Initial reset, two cycles, unchecked.
    i = idle(); i.rst = 1;
    drive(i);
    @(posedge clk);
    @(posedge clk);

    foreach (vecs[k]) apply(vecs[k].name, vecs[k].in, vecs[k].exp);

    // Breakpoint / step / resume sequence. Counters start at 15, 4, 3.
    bp = idle(); bp.bp_en = 1; bp.bp_addr = 32'h10;
    i = bp; i.inst_addr = 32'hC;
    apply("bp_before", i, mk(R_NONE, EN_ALL, 0, 0, 0, 0, 0, 15, 4, 3));
    i = bp; i.inst_addr = 32'h10;
    apply("bp_hit", i, mk(R_NONE, EN_NONE, 0, 0, 0, 0, 0, 16, 4, 3));
    i = bp; i.inst_addr = 32'h10; i.dbg_halt_req = 1;
    apply("halt_hold", i, mk(R_NONE, EN_NONE, 0, 0, 0, 0, 1, 16, 4, 3));
    i = bp; i.inst_addr = 32'h10; i.dbg_step = 1;
    apply("step_req", i, mk(R_NONE, EN_NONE, 0, 0, 0, 0, 1, 16, 4, 3));
    i = bp; i.inst_addr = 32'h10; i.is_beq = 1; i.rs_rt_equal = 1;
    apply("step_cycle", i, mk(R_ID, EN_ALL, 2, 0, 0, 0, 0, 16, 4, 3));
    i = bp; i.inst_addr = 32'h10; i.dbg_resume = 1; i.dbg_step = 1;
    apply("after_step", i, mk(R_NONE, EN_NONE, 0, 0, 0, 0, 1, 17, 4, 4));
    i = bp; i.inst_addr = 32'h10;
    apply("resume_skip_bp", i, mk(R_NONE, EN_ALL, 0, 0, 0, 0, 0, 17, 4, 4));
    i = bp; i.inst_addr = 32'h14;
    apply("run_on", i, mk(R_NONE, EN_ALL, 0, 0, 0, 0, 0, 18, 4, 4));
    i = bp; i.inst_addr = 32'h10;
    apply("bp_rehit", i, mk(R_NONE, EN_NONE, 0, 0, 0, 0, 0, 19, 4, 4));
    i = bp; i.inst_addr = 32'h10; i.dbg_resume = 1;
    apply("resume2", i, mk(R_NONE, EN_NONE, 0, 0, 0, 0, 1, 19, 4, 4));
    i = idle(); i.inst_addr = 32'h14; i.dbg_halt_req = 1;
    apply("halt_req", i, mk(R_NONE, EN_NONE, 0, 0, 0, 0, 0, 19, 4, 4));
    i = idle(); i.dbg_resume = 1;
    apply("resume3", i, mk(R_NONE, EN_NONE, 0, 0, 0, 0, 1, 19, 4, 4));
    i = idle();
    apply("run_idle", i, mk(R_NONE, EN_ALL, 0, 0, 0, 0, 0, 19, 4, 4));

    // Reset in the middle of a stall.
    i = idle(); i.addr_rs = 3; i.rs_used = 1;
    i.regw_addr_exe = 3; i.wb_wen_exe = 1; i.is_load_exe = 1;
    apply("pre_rst_stall", i, mk(R_EXE, EN_STALL, 0, 0, 0, 0, 0, 20, 4, 4));
    i.rst = 1;
    apply("rst_mid_stall", i, mk(R_ALL, EN_NONE, 0, 0, 0, 0, 0, 21, 5, 4));
    i = idle();
    apply("post_rst", i, mk(R_NONE, EN_ALL, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
